// File: rtl/seq_div_pkg.sv
// rtl/seq_div_pkg.sv - shared state encoding and constants for the sequential divider
package seq_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    // Sliced down to WIDTH bits by the divider when a zero divisor is seen.
    localparam logic [63:0] ZERO_DIV_QUOT = 64'hFFFF_FFFF_FFFF_FFFF;

endpackage

// File: rtl/seq_div_step.sv
// rtl/seq_div_step.sv - one combinational restoring-division iteration
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             dvd_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;

    // The restored remainder is always below the divisor, so it fits back into WIDTH bits.
    always_comb begin
        shifted = {rem_in, dvd_bit};
        q_bit   = (shifted >= {1'b0, divisor});
        diff    = shifted[WIDTH-1:0] - divisor;
        rem_out = q_bit ? diff : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/seq_div.sv
// rtl/seq_div.sv - radix-2 restoring sequential divider with signed/unsigned modes
module seq_div
    import seq_div_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             is_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int             CW        = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]  LAST_STEP = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             signed_mode;
    logic             dvd_neg, dvs_neg;
    logic [WIDTH-1:0] dvd_mag, dvs_mag;
    logic [WIDTH-1:0] step_rem, quo_next;
    logic             step_bit;

    // quo_q starts as the dividend magnitude and fills with quotient bits as it shifts left.
    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem_q),
        .dvd_bit (quo_q[WIDTH-1]),
        .divisor (dvs_q),
        .rem_out (step_rem),
        .q_bit   (step_bit)
    );

    always_comb begin
        signed_mode = SIGNED_EN && is_signed;
        dvd_neg     = signed_mode && dividend[WIDTH-1];
        dvs_neg     = signed_mode && divisor[WIDTH-1];
        dvd_mag     = dvd_neg ? -dividend : dividend;
        dvs_mag     = dvs_neg ? -divisor : divisor;
        quo_next    = {quo_q[WIDTH-2:0], step_bit};

        state_d     = state_q;
        out_valid_d = out_valid_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
        cnt_d       = cnt_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (divisor == '0) begin
                        state_d     = DONE;
                        out_valid_d = 1'b1;
                        quotient_d  = ZERO_DIV_QUOT[WIDTH-1:0];
                        remainder_d = dividend;
                        dbz_d       = 1'b1;
                    end else begin
                        state_d   = CALC;
                        rem_d     = '0;
                        quo_d     = dvd_mag;
                        dvs_d     = dvs_mag;
                        neg_quo_d = dvd_neg ^ dvs_neg;
                        neg_rem_d = dvd_neg;
                        cnt_d     = '0;
                    end
                end
            end
            CALC: begin
                rem_d = step_rem;
                quo_d = quo_next;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_STEP) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    quotient_d  = neg_quo_q ? -quo_next : quo_next;
                    remainder_d = neg_rem_q ? -step_rem : step_rem;
                    dbz_d       = 1'b0;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
            cnt_q       <= cnt_d;
        end
    end

    // in_ready must already be low while rst is held, before any reset edge lands.
    assign in_ready    = in_ready_q & ~rst;
    assign out_valid   = out_valid_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_div.sv
// tb/tb_seq_div.sv - self-checking bench for seq_div against an arithmetic reference model
module tb_seq_div;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         is_signed = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int total = 0;
    int bad   = 0;

    seq_div #(.WIDTH(W), .SIGNED_EN(1'b1)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .is_signed   (is_signed),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input bit s,
                           output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
        longint sa, sb;
        if (b == 0) begin
            q = '1;
            r = a;
            z = 1'b1;
        end else if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = W'(sa / sb);
            r  = W'(sa % sb);
            z  = 1'b0;
        end else begin
            q = a / b;
            r = a % b;
            z = 1'b0;
        end
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit s, input int hold);
        logic [W-1:0] eq, er;
        logic         ez;
        int           n, exp_lat;
        bit           rdy_low, stable;
        ref_div(a, b, s, eq, er, ez);
        exp_lat = (b == 0) ? 1 : W + 1;
        n = 0;
        while (!in_ready && n < 100) begin
            step();
            n++;
        end
        check("in_ready_idle", in_ready, 1'b1);
        dividend  = a;
        divisor   = b;
        is_signed = s;
        in_valid  = 1'b1;
        step();
        in_valid  = 1'b0;
        dividend  = $urandom;
        divisor   = $urandom;
        is_signed = 1'($urandom);
        n = 1;
        rdy_low = 1'b1;
        while (!out_valid && n < 200) begin
            rdy_low &= !in_ready;
            step();
            n++;
        end
        check("latency", n, exp_lat);
        check("in_ready_busy", rdy_low, 1'b1);
        check("in_ready_done", in_ready, 1'b0);
        check("quotient", quotient, eq);
        check("remainder", remainder, er);
        check("div_by_zero", div_by_zero, ez);
        stable = 1'b1;
        repeat (hold) begin
            step();
            stable &= out_valid && (quotient == eq) && (remainder == er)
                      && (div_by_zero == ez) && !in_ready;
        end
        if (hold > 0) check("done_hold", stable, 1'b1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("drained", out_valid, 1'b0);
        check("in_ready_after", in_ready, 1'b1);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        bit           rs;
        int           pick;

        rst = 1'b1;
        #1;
        check("rst_in_ready_pre_edge", in_ready, 1'b0);
        repeat (3) step();
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_quotient", quotient, 32'h0);
        check("rst_remainder", remainder, 32'h0);
        check("rst_dbz", div_by_zero, 1'b0);
        rst = 1'b0;
        #1;
        check("rst_release_in_ready", in_ready, 1'b1);

        run_op(32'd100, 32'd7, 1'b0, 0);
        run_op(-32'sd7, 32'd2, 1'b1, 0);
        run_op(32'd7, -32'sd2, 1'b1, 0);
        run_op(-32'sd7, 32'd2, 1'b0, 0);
        run_op(32'd5, 32'd0, 1'b0, 0);
        run_op(-32'sd9, 32'd0, 1'b1, 2);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);
        run_op(32'd0, -32'sd13, 1'b1, 0);
        run_op(32'hFFFF_FFFF, 32'd1, 1'b0, 0);
        run_op(32'd123, 32'd45, 1'b1, 10);

        dividend  = 32'd1000;
        divisor   = 32'd3;
        is_signed = 1'b0;
        in_valid  = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (11) step();
        rst = 1'b1;
        step();
        check("abort_out_valid", out_valid, 1'b0);
        check("abort_quotient", quotient, 32'h0);
        check("abort_remainder", remainder, 32'h0);
        check("abort_dbz", div_by_zero, 1'b0);
        check("abort_in_ready_rst", in_ready, 1'b0);
        rst = 1'b0;
        #1;
        check("abort_in_ready", in_ready, 1'b1);
        repeat (40) step();
        check("abort_no_result", out_valid, 1'b0);
        run_op(32'd9, 32'd3, 1'b0, 0);

        for (int i = 0; i < 25; i++) begin
            pick = int'($urandom_range(0, 4));
            ra   = (pick == 4) ? W'($urandom_range(0, 50)) : W'($urandom);
            case (pick)
                0:       rb = '0;
                1:       rb = W'($urandom_range(1, 15));
                2:       rb = -W'($urandom_range(1, 15));
                default: rb = W'($urandom);
            endcase
            rs = 1'($urandom);
            run_op(ra, rb, rs, int'($urandom_range(0, 2)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_div.md
SEQ_DIV -- requirements
Module: seq_div

Interface
REQ-001 SHALL have parameter WIDTH, default 32, setting operand/result width; legal range 4..64.
REQ-002 SHALL have parameter SIGNED_EN, default 1; when 1, the is_signed input selects signed mode; when 0, is_signed is ignored and all operations are unsigned.
REQ-003 SHALL have port clk  input  1  the single clock; all logic is on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port in_valid  input  1  operands present.
REQ-006 SHALL have port in_ready  output  1  block can accept operands.
REQ-007 SHALL have port dividend  input  WIDTH  numerator.
REQ-008 SHALL have port divisor  input  WIDTH  denominator.
REQ-009 SHALL have port is_signed  input  1  two's-complement mode for this operation.
REQ-010 SHALL have port out_valid  output  1  result present.
REQ-011 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-012 SHALL have port quotient  output  WIDTH  result quotient.
REQ-013 SHALL have port remainder  output  WIDTH  result remainder.
REQ-014 SHALL have port div_by_zero  output  1  the result came from a zero divisor.

Function
REQ-015 SHALL implement states IDLE, CALC and DONE.
REQ-016 SHALL assert in_ready only in IDLE; an input transfer occurs on a clock edge with in_valid=1 and in_ready=1, and operands and mode are captured at that edge.
REQ-017 SHALL go from IDLE to CALC on a transfer with a nonzero divisor, and from IDLE to DONE on a transfer with a zero divisor.
REQ-018 SHALL perform radix-2 restoring division on magnitudes, one quotient bit per cycle, MSB first, using a WIDTH+1-bit partial remainder.
REQ-019 SHALL remain in CALC exactly WIDTH cycles, then enter DONE.
REQ-020 SHALL give latency as follows: transfer at edge k means out_valid=1 from edge k+WIDTH+1 for a nonzero divisor, and from edge k+1 for a zero divisor.
REQ-021 SHALL hold out_valid and all result outputs stable in DONE until an edge with out_ready=1, then return to IDLE.
REQ-022 SHALL NOT assert in_ready in the DONE-exit cycle; a new transfer is accepted at the earliest one cycle after leaving DONE.
REQ-023 SHALL, in signed mode, negate the quotient when the operand signs differ and give the remainder the dividend's sign; unsigned mode returns raw magnitudes.
REQ-024 SHALL, on a zero divisor, output quotient all-ones, remainder equal to the dividend, and div_by_zero=1.
REQ-025 SHALL output div_by_zero=0 for every other result.
REQ-026 SHALL, for signed MIN/-1, output quotient MIN and remainder 0 with div_by_zero=0.
REQ-027 SHALL, for a zero dividend with a nonzero divisor, output quotient 0 and remainder 0 after the full WIDTH-cycle latency; there is no early-out.
REQ-028 SHALL always satisfy dividend == quotient*divisor + remainder (mod 2^WIDTH) and |remainder| < |divisor| for a nonzero divisor.
REQ-029 SHALL ignore changes on dividend, divisor and is_signed outside the transfer edge.

Reset
REQ-030 SHALL, on any edge with rst=1, enter IDLE regardless of state, aborting any CALC in progress with no result produced.
REQ-031 SHALL, during and after reset, drive in_ready=0 while rst=1 and in_ready=1 on the first cycle after rst is released.
REQ-032 SHALL, during and after reset, drive out_valid=0, quotient=0, remainder=0 and div_by_zero=0.
REQ-033 SHALL give rst priority over every handshake occurring on the same edge.

Structure
REQ-034 SHALL place the state enumeration and the zero-divisor quotient constant (all-ones) in the shared package seq_div_pkg.
REQ-035 SHALL use one natural sub-module, div_step: a combinational single restoring iteration (shift, compare, subtract, quotient bit), parametrised by WIDTH.
REQ-036 SHALL keep the iteration counter at $clog2(WIDTH)+1 bits.

Verification
REQ-037 SHALL cover: WIDTH=32, unsigned 100/7 -> quotient=14, remainder=2, out_valid exactly 33 cycles after the transfer.
REQ-038 SHALL cover: signed -7/2 -> quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1); and signed 7/-2 -> quotient=-3, remainder=1.
REQ-039 SHALL cover: 5/0 -> quotient=0xFFFFFFFF, remainder=5, div_by_zero=1, out_valid 1 cycle after the transfer.
REQ-040 SHALL cover: signed 0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0, div_by_zero=0.
REQ-041 SHALL cover: out_ready held 0 for 10 cycles in DONE -> outputs stable and in_ready=0 throughout; the result drains on the first out_ready=1 edge.
REQ-042 SHALL cover: rst=1 at CALC cycle 12 -> next cycle IDLE with all outputs 0; a following 9/3 transfer yields quotient=3, remainder=0 with normal latency.
